// File: rtl/mips_pkg.sv
// Shared types for the MIPS instruction-fetch front end.
package mips_pkg;

  localparam int INST_W = 32;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DISCARD = 2'd1,
    HALTED  = 2'd2
  } fetch_state_t;

  // Default prefetch entry for a 32-bit address space; the fetch unit
  // builds an equivalent struct sized to its own ADDR_W.
  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; DEPTH must be a power of two so the
// read/write pointers wrap naturally.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  entry_t           data_i,
  input  logic             pop_i,
  output entry_t           head_o,
  output logic [CNT_W-1:0] count_o
);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Pointer and count update; a flush empties the queue and wins over a push.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Pointer/count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because count gates validity.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/mips_fetch_unit.sv
// Decoupled instruction-fetch stage: fetch PC, imem req/ack handshake,
// prefetch queue towards decode, redirect/halt handling with discard of
// an in-flight request.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int               CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              halt,
  output logic              halted,
  output logic [CNT_W-1:0]  occupancy
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pending_pc_q, pending_pc_d;
  logic              halt_pending_q, halt_pending_d;

  logic [CNT_W-1:0]  count;
  entry_t            head;
  entry_t            push_entry;
  logic              flush, push, pop, xfer;
  logic [ADDR_W-1:0] target;

  assign target     = redirect_target & ~ADDR_W'(3);
  assign push_entry = '{pc: fetch_pc_q, inst: imem_rdata};
  assign inst_valid = !rst && (count != '0);
  assign pop        = inst_valid && inst_ready;
  assign xfer       = imem_req && imem_ack;

  // Request generation and next-state logic; halt beats redirect, and a
  // request already on the bus is always completed before its data is dropped.
  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    pending_pc_d   = pending_pc_q;
    halt_pending_d = halt_pending_q;
    flush          = 1'b0;
    push           = 1'b0;
    imem_req       = 1'b0;

    case (state_q)
      RUN:     imem_req = !rst && (count < CNT_W'(DEPTH));
      DISCARD: imem_req = !rst;
      default: imem_req = 1'b0;
    endcase

    case (state_q)
      RUN: begin
        if (halt) begin
          flush          = 1'b1;
          halt_pending_d = 1'b1;
          state_d        = (imem_req && !imem_ack) ? DISCARD : HALTED;
        end else if (redirect_valid) begin
          flush = 1'b1;
          if (!imem_req || imem_ack) begin
            fetch_pc_d = target;
          end else begin
            pending_pc_d   = target;
            halt_pending_d = 1'b0;
            state_d        = DISCARD;
          end
        end else if (xfer) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        end
      end
      DISCARD: begin
        if (halt) begin
          flush          = 1'b1;
          halt_pending_d = 1'b1;
          if (xfer) state_d = HALTED;
        end else begin
          if (redirect_valid) begin
            flush        = 1'b1;
            pending_pc_d = target;
          end
          if (xfer) begin
            if (halt_pending_q) begin
              state_d = HALTED;
            end else begin
              fetch_pc_d = redirect_valid ? target : pending_pc_q;
              state_d    = RUN;
            end
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Control registers with synchronous reset back to fetching at RESET_PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      fetch_pc_q     <= RESET_PC;
      pending_pc_q   <= RESET_PC;
      halt_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      pending_pc_q   <= pending_pc_d;
      halt_pending_q <= halt_pending_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count)
  );

  assign imem_addr = fetch_pc_q;
  assign inst_data = head.inst;
  assign inst_pc   = head.pc;
  assign halted    = (state_q == HALTED);
  assign occupancy = count;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: queue-based reference model
// compared every cycle, plus hand-computed directed expectations.
module tb_mips_fetch_unit;

  localparam int DEPTH  = 4;
  localparam int M_RUN  = 0;
  localparam int M_DISC = 1;
  localparam int M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instReady = 1'b1;
  logic        redirValid = 1'b0;
  logic [31:0] redirTarget = '0;
  logic        haltReq = 1'b0;

  logic        imem_req, imem_ack, inst_valid, halted;
  logic [31:0] imem_addr, imem_rdata, inst_data, inst_pc;
  logic [2:0]  occupancy;

  logic        wReq, wValid, wHalted;
  logic [31:0] wAddr, wRdata, wData, wPc;
  logic [2:0]  wOcc;

  int checks = 0;
  int failures = 0;
  int memLatency = 0;
  int waitCnt = 0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + 32'h0000_1357;
  endfunction

  always #5 clk = ~clk;

  mips_fetch_unit #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(instReady),
    .redirect_valid(redirValid), .redirect_target(redirTarget), .halt(haltReq),
    .halted(halted), .occupancy(occupancy)
  );

  mips_fetch_unit #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .rst(rst),
    .imem_req(wReq), .imem_addr(wAddr), .imem_ack(wReq), .imem_rdata(wRdata),
    .inst_valid(wValid), .inst_data(wData), .inst_pc(wPc), .inst_ready(1'b1),
    .redirect_valid(1'b0), .redirect_target(32'h0), .halt(1'b0),
    .halted(wHalted), .occupancy(wOcc)
  );

  assign wRdata     = memWord(wAddr);
  assign imem_rdata = memWord(imem_addr);
  assign imem_ack   = imem_req && (waitCnt >= memLatency);

  // Memory responder: acknowledges after memLatency waiting cycles.
  always @(posedge clk) begin
    if (imem_req && !imem_ack) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit rdy, input bit rv, input logic [31:0] rt, input bit h);
    @(posedge clk);
    #1;
    rst = r; instReady = rdy; redirValid = rv; redirTarget = rt; haltReq = h;
  endtask

  task automatic sampleCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic doReset(input int lat, input bit rdy);
    memLatency = lat;
    applyStimulus(1, rdy, 0, 0, 0);
    applyStimulus(1, rdy, 0, 0, 0);
  endtask

  // Reference model: fetch behaviour expressed as a PC, a queue and a mode.
  int          mMode = M_RUN;
  logic [31:0] mFetchPc = '0;
  logic [31:0] mPending = '0;
  bit          mHaltAfter = 0;
  logic [63:0] mQ[$];

  // Compare the DUT against the model every cycle, then advance the model.
  always @(negedge clk) begin
    bit eReq, eValid, xfer, pop;
    logic [31:0] tgt;
    eReq   = !rst && ((mMode == M_RUN && mQ.size() < DEPTH) || mMode == M_DISC);
    eValid = !rst && (mQ.size() != 0);
    checkOutput("m_req", imem_req, eReq);
    checkOutput("m_valid", inst_valid, eValid);
    if (eReq) checkOutput("m_addr", imem_addr, mFetchPc);
    if (eValid) begin
      checkOutput("m_pc", inst_pc, mQ[0][63:32]);
      checkOutput("m_data", inst_data, mQ[0][31:0]);
    end
    if (!rst) begin
      checkOutput("m_occ", occupancy, mQ.size());
      checkOutput("m_halted", halted, mMode == M_HALT);
    end
    xfer = eReq && imem_ack;
    pop  = eValid && instReady;
    tgt  = (redirTarget / 4) * 4;
    if (rst) begin
      mMode = M_RUN; mFetchPc = 32'h0; mHaltAfter = 0; mQ.delete();
    end else if (mMode == M_HALT) begin
    end else if (haltReq) begin
      mQ.delete();
      if (eReq && !xfer) begin mMode = M_DISC; mHaltAfter = 1; end
      else mMode = M_HALT;
    end else if (redirValid) begin
      mQ.delete();
      if (mMode == M_RUN) begin
        if (xfer || !eReq) mFetchPc = tgt;
        else begin mMode = M_DISC; mPending = tgt; mHaltAfter = 0; end
      end else begin
        mPending = tgt;
        if (xfer) begin
          if (mHaltAfter) mMode = M_HALT;
          else begin mFetchPc = tgt; mMode = M_RUN; end
        end
      end
    end else begin
      if (pop) void'(mQ.pop_front());
      if (xfer) begin
        if (mMode == M_RUN) begin
          mQ.push_back({mFetchPc, memWord(mFetchPc)});
          mFetchPc = mFetchPc + 32'd4;
        end else if (mHaltAfter) mMode = M_HALT;
        else begin mFetchPc = mPending; mMode = M_RUN; end
      end
    end
  end

  initial begin
    bit found;
    bit [15:0] readyPattern;
    readyPattern = 16'b1011_0010_1110_0111;

    // Streaming with zero-wait memory, plus the RESET_PC wrap instance.
    doReset(0, 1);
    applyStimulus(0, 1, 0, 0, 0);
    sampleCycle();
    checkOutput("p1_addr0", imem_addr, 32'h0);
    checkOutput("p1_req0", imem_req, 1);
    checkOutput("wrap_addr0", wAddr, 32'hFFFF_FFFC);
    applyStimulus(0, 1, 0, 0, 0);
    sampleCycle();
    checkOutput("p1_addr1", imem_addr, 32'h4);
    checkOutput("p1_pc1", inst_pc, 32'h0);
    checkOutput("wrap_addr1", wAddr, 32'h0);
    checkOutput("wrap_pc1", wPc, 32'hFFFF_FFFC);
    applyStimulus(0, 1, 0, 0, 0);
    sampleCycle();
    checkOutput("p1_addr2", imem_addr, 32'h8);
    checkOutput("p1_pc2", inst_pc, 32'h4);
    checkOutput("p1_occ2", occupancy, 1);

    // Back-pressure fills the queue, one pop restarts fetch at 0x10.
    doReset(0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    sampleCycle();
    checkOutput("p2_occFull", occupancy, 4);
    checkOutput("p2_reqLow", imem_req, 0);
    checkOutput("p2_head", inst_pc, 32'h0);
    applyStimulus(0, 0, 0, 0, 0);
    sampleCycle();
    checkOutput("p2_reqBack", imem_req, 1);
    checkOutput("p2_addr10", imem_addr, 32'h10);
    checkOutput("p2_head2", inst_pc, 32'h4);
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0, 0, 0);

    // Latency 3, redirect while the request at 0x8 is pending.
    doReset(3, 1);
    found = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(0, 1, 0, 0, 0);
      sampleCycle();
      if (imem_req && imem_addr == 32'h8 && !imem_ack) begin found = 1; break; end
    end
    checkOutput("p3_found8", found, 1);
    applyStimulus(0, 1, 1, 32'h103, 0);
    sampleCycle();
    checkOutput("p3_addrHeld", imem_addr, 32'h8);
    checkOutput("p3_noAck", imem_ack, 0);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 0, 0, 0);
      sampleCycle();
      checkOutput("p3_emptyDiscard", inst_valid, 0);
      if (imem_ack) begin found = 1; break; end
    end
    checkOutput("p3_ackSeen", found, 1);
    applyStimulus(0, 1, 0, 0, 0);
    sampleCycle();
    checkOutput("p3_addr100", imem_addr, 32'h100);
    checkOutput("p3_empty", inst_valid, 0);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 0, 0, 0);
      sampleCycle();
      if (inst_valid) begin found = 1; break; end
    end
    checkOutput("p3_validSeen", found, 1);
    checkOutput("p3_pc100", inst_pc, 32'h100);

    // Redirect coinciding with an ack.
    doReset(0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 32'h200, 0);
    sampleCycle();
    checkOutput("p4_ackSame", imem_ack, 1);
    applyStimulus(0, 1, 0, 0, 0);
    sampleCycle();
    checkOutput("p4_addr200", imem_addr, 32'h200);
    checkOutput("p4_notQueued", inst_valid, 0);
    applyStimulus(0, 1, 0, 0, 0);
    sampleCycle();
    checkOutput("p4_pc200", inst_pc, 32'h200);

    // Halt with a pending request, then ignore later redirect/halt.
    doReset(2, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    sampleCycle();
    checkOutput("p5_pendNoAck", imem_ack, 0);
    applyStimulus(0, 0, 0, 0, 0);
    sampleCycle();
    checkOutput("p5_ackDrop", imem_ack, 1);
    checkOutput("p5_notYetHalted", halted, 0);
    applyStimulus(0, 0, 0, 0, 0);
    sampleCycle();
    checkOutput("p5_halted", halted, 1);
    checkOutput("p5_reqOff", imem_req, 0);
    checkOutput("p5_occ0", occupancy, 0);
    applyStimulus(0, 1, 1, 32'h300, 0);
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0);
    sampleCycle();
    checkOutput("p5_stillHalted", halted, 1);
    checkOutput("p5_stillNoReq", imem_req, 0);
    doReset(0, 1);
    applyStimulus(0, 1, 0, 0, 0);
    sampleCycle();
    checkOutput("p5_restartAddr", imem_addr, 32'h0);
    checkOutput("p5_restartHalted", halted, 0);

    // Halt while idle (queue full, no request).
    doReset(0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    sampleCycle();
    checkOutput("p6_idleHalted", halted, 1);
    checkOutput("p6_flushed", inst_valid, 0);

    // Mixed traffic: latency 1, irregular ready, two redirects.
    doReset(1, 1);
    for (int i = 0; i < 48; i++) begin
      if (i == 20) applyStimulus(0, readyPattern[i % 16], 1, 32'h41, 0);
      else if (i == 33) applyStimulus(0, readyPattern[i % 16], 1, 32'h80, 0);
      else applyStimulus(0, readyPattern[i % 16], 0, 0, 0);
    end
    applyStimulus(0, 1, 0, 0, 0);
    sampleCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
